run_monitor: RTL and testbench

//   Synthesisable run-control and performance monitor for the sequential core.

---
 rtl/run_monitor_if.sv | 30 +++
 rtl/run_monitor.sv | 136 +++++++++++++
 tb/tb_run_monitor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_monitor_if.sv
// Signal bundle between a core-side driver and run_monitor: run control, instruction tap,
// counter readback and PC-history readback.
interface run_monitor_if #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned HIST_DEPTH = 8
);
    localparam int unsigned HistIdxW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic                start;
    logic                clear;
    logic                instr_valid;
    logic [31:0]         instr;
    logic [31:0]         pc;
    logic [2:0]          cnt_sel;
    logic [CNT_W-1:0]    cnt_rdata;
    logic [1:0]          state;
    logic                done;
    logic [HistIdxW-1:0] hist_idx;
    logic [31:0]         hist_pc;

    modport master (
        output start, clear, instr_valid, instr, pc, cnt_sel, hist_idx,
        input  cnt_rdata, state, done, hist_pc
    );

    modport slave (
        input  start, clear, instr_valid, instr, pc, cnt_sel, hist_idx,
        output cnt_rdata, state, done, hist_pc
    );
endinterface

// File: rtl/run_monitor.sv
// Run-control and performance monitor: cycle/instret/per-class counters, halt and timeout
// detection. Define RUN_MON_HIST_EN to build the PC history buffer.
module run_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 500,
    parameter logic [31:0] HALT_INSTR = 32'h00000000,
    parameter int unsigned HIST_DEPTH = 8
) (
    input logic        clk,
    input logic        reset_n,
    run_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StHalt    = 2'b10,
        StTimeout = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [63:0]      MaxCyc = 64'(MAX_CYCLES);

    // Counter slots match cnt_sel: 0..5 instruction classes, 6 cycles, 7 instret.
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [2:0]       cls;
    logic             is_halt, retire, cnt_clr, run_cnt;
    logic [CNT_W-1:0] cyc_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        cls = 3'd5;
        unique case (bus.instr[6:0])
            7'b0110011: cls = 3'd0;
            7'b0010011: cls = 3'd1;
            7'b0000011: cls = 3'd2;
            7'b0100011: cls = 3'd3;
            7'b1100011: cls = 3'd4;
            default:    cls = 3'd5;
        endcase
    end

    always_comb begin
        is_halt = bus.instr_valid && (bus.instr == HALT_INSTR);
        retire  = bus.instr_valid && !is_halt;
        cyc_inc = sat_inc(cnt_q[6]);
        state_d = state_q;
        cnt_clr = 1'b0;
        run_cnt = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start && !bus.clear) begin
                    state_d = StRun;
                    cnt_clr = 1'b1;
                end
            end
            StRun: begin
                if (bus.clear) begin
                    state_d = StIdle;
                end else begin
                    run_cnt = 1'b1;
                    // Halt takes priority over a budget expiry in the same cycle.
                    if (is_halt) begin
                        state_d = StHalt;
                    end else if (64'(cyc_inc) == MaxCyc) begin
                        state_d = StTimeout;
                    end
                end
            end
            StHalt, StTimeout: begin
                if (bus.clear) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < 8; i++) cnt_d[i] = cnt_q[i];
        if (cnt_clr) begin
            for (int i = 0; i < 8; i++) cnt_d[i] = '0;
        end else if (run_cnt) begin
            cnt_d[6] = cyc_inc;
            if (retire) begin
                cnt_d[7]   = sat_inc(cnt_q[7]);
                cnt_d[cls] = sat_inc(cnt_q[cls]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.cnt_rdata = cnt_q[bus.cnt_sel];
    assign bus.state     = state_q;
    assign bus.done      = state_q[1];

`ifdef RUN_MON_HIST_EN
    localparam int unsigned HistIdxW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [31:0]         hist_q [HIST_DEPTH];
    logic [HistIdxW-1:0] wr_ptr_q, rd_ptr;
    logic [HistIdxW:0]   fill_q;

    // fill_q masks slots not yet written since the last start so they read as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (cnt_clr) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (run_cnt && retire) begin
            hist_q[wr_ptr_q] <= bus.pc;
            wr_ptr_q         <= wr_ptr_q + HistIdxW'(1);
            if (fill_q != (HistIdxW + 1)'(HIST_DEPTH)) fill_q <= fill_q + (HistIdxW + 1)'(1);
        end
    end

    assign rd_ptr      = wr_ptr_q - HistIdxW'(1) - bus.hist_idx;
    assign bus.hist_pc = ({1'b0, bus.hist_idx} < fill_q) ? hist_q[rd_ptr] : 32'h0;
`else
    logic unused_hist;
    assign unused_hist = ^{bus.hist_idx, bus.pc};
    assign bus.hist_pc = 32'h0;
`endif
endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed scenarios plus randomized traffic checked
// against a behavioural model of the counters, FSM and PC history.
module tb_run_monitor;
    localparam int unsigned CntW      = 32;
    localparam int unsigned SmallW    = 4;
    localparam int unsigned MaxCycles = 500;
    localparam int unsigned HistDepth = 8;
    localparam longint     CntMax     = (64'd1 << CntW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    run_monitor_if #(.CNT_W(CntW), .HIST_DEPTH(HistDepth)) bus ();
    run_monitor_if #(.CNT_W(SmallW), .HIST_DEPTH(HistDepth)) sbus ();

    run_monitor #(.CNT_W(CntW), .MAX_CYCLES(MaxCycles), .HALT_INSTR(32'h0),
                  .HIST_DEPTH(HistDepth)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    run_monitor #(.CNT_W(SmallW), .MAX_CYCLES(MaxCycles), .HALT_INSTR(32'h0),
                  .HIST_DEPTH(HistDepth)) dut_small (
        .clk(clk), .reset_n(reset_n), .bus(sbus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state as 0 idle / 1 run / 2 halt / 3 timeout.
    int          m_state;
    longint      m_cnt [8];
    logic [31:0] m_hist [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int op_class(input logic [31:0] ins);
        case (ins[6:0])
            7'h33:   return 0;
            7'h13:   return 1;
            7'h03:   return 2;
            7'h23:   return 3;
            7'h63:   return 4;
            default: return 5;
        endcase
    endfunction

    function automatic longint sat(input longint v);
        return (v > CntMax) ? CntMax : v;
    endfunction

    function automatic logic [31:0] exp_hist(input int idx);
`ifdef RUN_MON_HIST_EN
        return (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic st, input logic cl, input logic v,
                              input logic [31:0] ins, input logic [31:0] p);
        case (m_state)
            0: if (st && !cl) begin
                for (int i = 0; i < 8; i++) m_cnt[i] = 0;
                m_hist.delete();
                m_state = 1;
            end
            1: if (cl) begin
                m_state = 0;
            end else begin
                m_cnt[6] = sat(m_cnt[6] + 1);
                if (v && ins == 32'h0) begin
                    m_state = 2;
                end else begin
                    if (v) begin
                        m_cnt[7] = sat(m_cnt[7] + 1);
                        m_cnt[op_class(ins)] = sat(m_cnt[op_class(ins)] + 1);
                        m_hist.push_front(p);
                        if (m_hist.size() > HistDepth) void'(m_hist.pop_back());
                    end
                    if (m_cnt[6] == MaxCycles) m_state = 3;
                end
            end
            default: if (cl) m_state = 0;
        endcase
    endtask

    task automatic tick(input logic st, input logic cl, input logic v,
                        input logic [31:0] ins, input logic [31:0] p);
        bus.start       = st;
        bus.clear       = cl;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.pc          = p;
        @(posedge clk);
        model_step(st, cl, v, ins, p);
        #1;
        check_eq("state", 64'(bus.state), 64'(m_state));
        check_eq("done", 64'(bus.done), 64'(m_state >= 2));
        check_eq($sformatf("cnt_sel%0d", bus.cnt_sel), 64'(bus.cnt_rdata),
                 64'(m_cnt[bus.cnt_sel]));
        check_eq($sformatf("hist_idx%0d", bus.hist_idx), 64'(bus.hist_pc),
                 64'(exp_hist(int'(bus.hist_idx))));
    endtask

    // Only used while the FSM is frozen, so the idle cycle changes nothing.
    task automatic read_cnt(input string tag, input logic [2:0] sel, input longint exp);
        bus.cnt_sel = sel;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq(tag, 64'(bus.cnt_rdata), 64'(exp));
    endtask

    task automatic read_hist(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        bus.hist_idx = idx;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq(tag, 64'(bus.hist_pc), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.clear = 0; bus.instr_valid = 0; bus.instr = 0; bus.pc = 0;
        bus.cnt_sel = 0; bus.hist_idx = 0;
        sbus.start = 0; sbus.clear = 0; sbus.instr_valid = 0; sbus.instr = 0; sbus.pc = 0;
        sbus.cnt_sel = 0; sbus.hist_idx = 0;
        model_reset();
        #12;
        check_eq("reset_state", 64'(bus.state), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_hist", 64'(bus.hist_pc), 64'd0);
        reset_n = 1'b1;

        // Narrow counters saturate instead of wrapping.
        sbus.start = 1;
        @(posedge clk); #1;
        sbus.start = 0; sbus.instr_valid = 1; sbus.instr = 32'h00208063;
        repeat (20) @(posedge clk);
        #1;
        sbus.instr = 32'h0;
        @(posedge clk); #1;
        sbus.instr_valid = 0;
        check_eq("t4_state", 64'(sbus.state), 64'd2);
        sbus.cnt_sel = 4; #1;
        check_eq("t4_sel4", 64'(sbus.cnt_rdata), 64'd15);
        sbus.cnt_sel = 7; #1;
        check_eq("t4_sel7", 64'(sbus.cnt_rdata), 64'd15);
        sbus.cnt_sel = 6; #1;
        check_eq("t4_sel6", 64'(sbus.cnt_rdata), 64'd15);

        // Halt after a mixed instruction stream.
        tick(1, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 32'h002081B3, 32'(i * 4));
        for (int i = 0; i < 2; i++) tick(0, 0, 1, 32'h0002A303, 32'h100 + 32'(i * 4));
        tick(0, 0, 1, 32'h0062A023, 32'h200);
        tick(0, 0, 1, 32'h0, 32'h204);
        check_eq("t2_state", 64'(bus.state), 64'd2);
        read_cnt("t2_sel0", 3'd0, 3);
        read_cnt("t2_sel2", 3'd2, 2);
        read_cnt("t2_sel3", 3'd3, 1);
        read_cnt("t2_sel7", 3'd7, 6);
        read_cnt("t2_sel6", 3'd6, 7);
        tick(1, 0, 0, 32'h0, 32'h0);
        check_eq("t2_start_ignored", 64'(bus.state), 64'd2);

        // Timeout, then halt landing exactly on the last budget cycle.
        tick(0, 1, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        repeat (MaxCycles) tick(0, 0, 1, 32'h00000013, 32'h40);
        check_eq("t3_timeout", 64'(bus.state), 64'd3);
        read_cnt("t3_sel6", 3'd6, 500);
        read_cnt("t3_sel1", 3'd1, 500);
        tick(0, 1, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        repeat (MaxCycles - 1) tick(0, 0, 1, 32'h00000013, 32'h40);
        tick(0, 0, 1, 32'h0, 32'h44);
        check_eq("t3_halt_wins", 64'(bus.state), 64'd2);
        read_cnt("t3b_sel6", 3'd6, 500);
        read_cnt("t3b_sel1", 3'd1, 499);

        // Abort mid-run with clear.
        tick(0, 1, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        repeat (5) tick(0, 0, 1'($urandom_range(0, 1)), 32'h002081B3, 32'h80);
        tick(1, 1, 1, 32'h002081B3, 32'h84);
        check_eq("t5_state", 64'(bus.state), 64'd0);
        read_cnt("t5_sel6", 3'd6, 5);
        bus.cnt_sel = 3'd6;
        tick(1, 0, 0, 32'h0, 32'h0);
        check_eq("t5_start_clr", 64'(bus.cnt_rdata), 64'd0);

        // PC history wraps around the eight-entry buffer.
        for (int i = 0; i < 11; i++) tick(0, 0, 1, 32'h002081B3, 32'(i * 4));
        tick(0, 0, 1, 32'h0, 32'h2C);
`ifdef RUN_MON_HIST_EN
        read_hist("t6_idx0", 3'd0, 32'h28);
        read_hist("t6_idx7", 3'd7, 32'h0C);
`else
        read_hist("t6_idx0", 3'd0, 32'h0);
        read_hist("t6_idx7", 3'd7, 32'h0);
`endif

        // Asynchronous reset in the middle of a run.
        tick(0, 1, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        repeat (10) tick(0, 0, 1, 32'h0002A303, 32'h300);
        reset_n = 1'b0;
        #2;
        model_reset();
        check_eq("t1_state", 64'(bus.state), 64'd0);
        check_eq("t1_done", 64'(bus.done), 64'd0);
        for (int s = 0; s < 8; s++) begin
            bus.cnt_sel = 3'(s);
            #1;
            check_eq($sformatf("t1_sel%0d", s), 64'(bus.cnt_rdata), 64'd0);
        end
        @(negedge clk);
        bus.start = 0; bus.clear = 0; bus.instr_valid = 0;
        reset_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            logic        st, cl, v, quiet;
            logic [31:0] ins;
            int          k;
            quiet = (n >= 1000 && n < 2000);
            bus.cnt_sel  = 3'($urandom_range(0, 7));
            bus.hist_idx = 3'($urandom_range(0, 7));
            st  = ($urandom_range(0, 19) == 0) || (m_state == 0 && $urandom_range(0, 1) == 0);
            cl  = quiet ? (m_state >= 2 && $urandom_range(0, 7) == 0)
                        : ($urandom_range(0, 39) == 0);
            v   = ($urandom_range(0, 3) != 0);
            ins = $urandom();
            k   = $urandom_range(0, 5);
            case (k)
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h63;
                default: ;
            endcase
            if (!quiet && $urandom_range(0, 49) == 0) ins = 32'h0;
            tick(st, cl, v, ins, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
